// File: rtl/key_cmd_scheduler_pkg.sv
// ============================================================================
// Module      : key_cmd_scheduler_pkg
// Description : Key bit indices, repeat FSM encoding and command entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_cmd_scheduler_pkg;

    localparam int KEY_LEFT    = 0;
    localparam int KEY_UP      = 1;
    localparam int KEY_DOWN    = 2;
    localparam int KEY_RIGHT   = 3;
    localparam int KEY_RETRY   = 4;
    localparam int KEY_NEXT    = 5;
    localparam int KEY_RETRACT = 6;
    localparam int KEY_SWITCH  = 7;

    localparam logic [7:0] MOVE_MASK = 8'h0F;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    typedef struct packed {
        logic       rpt;
        logic [2:0] code;
    } cmd_t;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_cmd_scheduler_cmd_fifo.sv
// ============================================================================
// Module      : cmd_fifo
// Description : Small command FIFO with single-cycle flush-and-load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_fifo
    import key_cmd_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  cmd_t       wdata_i,
    output cmd_t       rdata_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [4:0] level_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t           mem_q [DEPTH];
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  rptr_q;
    logic [4:0]     count_q;
    logic           w_push;
    logic           w_pop;

    assign full_o  = (count_q == 5'(DEPTH));
    assign empty_o = (count_q == 5'd0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    // Flush discards everything and loads the incoming entry as the sole head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= 5'd0;
        end else if (flush_i) begin
            mem_q[0] <= wdata_i;
            wptr_q   <= AW'(1);
            rptr_q   <= '0;
            count_q  <= 5'd1;
        end else begin
            if (w_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (w_pop) rptr_q <= rptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_cmd_scheduler.sv
// ============================================================================
// Module      : key_cmd_scheduler
// Description : Key press edge detection, movement auto-repeat and command queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_cmd_scheduler
    import key_cmd_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] key_in,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       cmd_repeat,
    output logic       overflow,
    output logic [4:0] fifo_level
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [7:0]       key_q;
    logic             armed_q;
    logic [7:0]       pend_q,     pend_d;
    logic [7:0]       pend_rep_q, pend_rep_d;
    logic             ovf_q,      ovf_d;
    logic [1:0]       state_q,    state_d;
    logic [1:0]       rep_key_q,  rep_key_d;
    logic [CNT_W-1:0] rep_cnt_q,  rep_cnt_d;

    logic [7:0]       w_press;
    logic [7:0]       w_mv_press;
    logic [2:0]       w_mv_idx;
    logic [3:0]       w_move_keys;
    logic             w_held;
    logic             w_tick;
    logic [7:0]       w_ev;
    logic [7:0]       w_ev_rep;
    logic [2:0]       w_sel;
    logic [7:0]       w_sel_oh;
    logic             w_any;
    logic             w_pop;
    logic             w_is_flush;
    logic             w_deq;
    logic [7:0]       w_keep;
    logic             w_full;
    logic             w_empty;
    cmd_t             w_wdata;
    cmd_t             w_rdata;

    // The first cycle after reset only captures key levels, so held keys make no edge.
    assign w_press     = armed_q ? (key_in & ~key_q) : 8'h00;
    assign w_mv_press  = w_press & MOVE_MASK;
    assign w_mv_idx    = lowest_idx(w_mv_press);
    assign w_move_keys = key_in[3:0];
    assign w_held      = w_move_keys[rep_key_q];

    always_comb begin
        state_d   = state_q;
        rep_key_d = rep_key_q;
        rep_cnt_d = rep_cnt_q;
        w_tick    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|w_mv_press) begin
                    state_d   = ST_DELAY;
                    rep_key_d = w_mv_idx[1:0];
                    rep_cnt_d = '0;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!w_held) begin
                    state_d   = ST_IDLE;
                    rep_cnt_d = '0;
                end else if (|w_mv_press) begin
                    state_d   = ST_DELAY;
                    rep_key_d = w_mv_idx[1:0];
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == ((state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                    state_d   = ST_REPEAT;
                    rep_cnt_d = '0;
                    w_tick    = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rep_cnt_d = '0;
            end
        endcase
    end

    assign w_ev_rep   = w_tick ? (8'h01 << rep_key_q) : 8'h00;
    assign w_ev       = w_press | w_ev_rep;

    assign w_any      = |pend_q;
    assign w_sel      = lowest_idx(pend_q);
    assign w_sel_oh   = 8'h01 << w_sel;
    assign w_pop      = cmd_valid & cmd_ready;
    assign w_is_flush = w_any & (w_sel == 3'(KEY_RETRY));
    assign w_deq      = w_any & (w_is_flush | ~w_full | w_pop);
    assign w_wdata    = '{rpt: pend_rep_q[w_sel], code: w_sel};

    // A flush dequeues bit 4 and discards every other pending bit.
    assign w_keep = w_is_flush ? 8'h00 : (pend_q & ~(w_deq ? w_sel_oh : 8'h00));

    // A merged event keeps the repeat tag only if both halves are repeats.
    assign pend_d     = w_keep | w_ev;
    assign pend_rep_d = (w_keep & pend_rep_q & (~w_ev | w_ev_rep)) | (~w_keep & w_ev_rep);
    assign ovf_d      = ovf_q | (|(w_ev & w_keep));

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            key_q      <= 8'h00;
            armed_q    <= 1'b0;
            pend_q     <= 8'h00;
            pend_rep_q <= 8'h00;
            ovf_q      <= 1'b0;
            state_q    <= ST_IDLE;
            rep_key_q  <= 2'd0;
            rep_cnt_q  <= '0;
        end else begin
            key_q      <= key_in;
            armed_q    <= 1'b1;
            pend_q     <= pend_d;
            pend_rep_q <= pend_rep_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            rep_key_q  <= rep_key_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_i   (reset),
        .push_i  (w_deq & ~w_is_flush),
        .pop_i   (w_pop),
        .flush_i (w_deq & w_is_flush),
        .wdata_i (w_wdata),
        .rdata_o (w_rdata),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (fifo_level)
    );

    assign cmd_valid  = ~w_empty;
    assign cmd_code   = w_rdata.code;
    assign cmd_repeat = w_rdata.rpt;
    assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_key_cmd_scheduler.sv
// ============================================================================
// Module      : tb_key_cmd_scheduler
// Description : Directed self-checking bench for key_cmd_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_cmd_scheduler;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic [7:0] key_in;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_repeat;
    logic       overflow;
    logic [4:0] fifo_level;

    int n_run  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    key_cmd_scheduler #(
        .FIFO_DEPTH    (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .key_in     (key_in),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_repeat (cmd_repeat),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},    32'(cmd_valid),  32'd0);
        chk({tag, "_code"},     32'(cmd_code),   32'd0);
        chk({tag, "_repeat"},   32'(cmd_repeat), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow),   32'd0);
        chk({tag, "_level"},    32'(fifo_level), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_v;

        // Reset state
        reset = 1'b1; key_in = 8'h00; cmd_ready = 1'b0;
        repeat (3) step();
        chk_zero("rst");
        reset = 1'b0;
        step(); step();

        // Single press of d_right, consumer ready
        cmd_ready = 1'b1;
        key_in = 8'h08; step();
        chk("p3_latency_valid", 32'(cmd_valid), 32'd0);
        key_in = 8'h00; step();
        chk("p3_valid", 32'(cmd_valid),  32'd1);
        chk("p3_code",  32'(cmd_code),   32'd3);
        chk("p3_rep",   32'(cmd_repeat), 32'd0);
        step();
        chk("p3_gone",  32'(cmd_valid),  32'd0);
        step();
        chk("p3_stay0", 32'(cmd_valid),  32'd0);

        // Simultaneous presses 0,2,5 queue in index order
        cmd_ready = 1'b0;
        key_in = 8'h25; step();
        key_in = 8'h00; step();
        chk("m_lvl1", 32'(fifo_level), 32'd1);
        chk("m_head", 32'(cmd_code),   32'd0);
        step();
        chk("m_lvl2", 32'(fifo_level), 32'd2);
        step();
        chk("m_lvl3", 32'(fifo_level), 32'd3);
        step();
        chk("m_lvl3_hold", 32'(fifo_level), 32'd3);
        chk("m_head_hold", 32'(cmd_code),   32'd0);
        cmd_ready = 1'b1; step();
        chk("m_pop1_code", 32'(cmd_code),   32'd2);
        chk("m_pop1_lvl",  32'(fifo_level), 32'd2);
        step();
        chk("m_pop2_code", 32'(cmd_code),   32'd5);
        step();
        chk("m_empty", 32'(cmd_valid), 32'd0);

        // Auto-repeat of w_up: fresh at +1, repeats at +11 then every 4 cycles
        key_in = 8'h02; step();
        for (int k = 1; k <= 40; k++) begin
            if (k == 29) key_in = 8'h00;
            step();
            exp_v = (k == 1) || (k >= 11 && k <= 27 && ((k - 11) % 4) == 0);
            chk($sformatf("rpt_valid_k%0d", k), 32'(cmd_valid), 32'(exp_v));
            if (exp_v) begin
                chk($sformatf("rpt_code_k%0d", k), 32'(cmd_code),   32'd1);
                chk($sformatf("rpt_tag_k%0d", k),  32'(cmd_repeat), 32'(k != 1));
            end
        end

        // Six presses into a depth-4 FIFO, then re-press a pending key
        cmd_ready = 1'b0;
        key_in = 8'h20; step();
        key_in = 8'h40; step();
        key_in = 8'h80; step();
        key_in = 8'h01; step();
        key_in = 8'h02; step();
        key_in = 8'h04; step();
        key_in = 8'h00;
        chk("ov_full_lvl", 32'(fifo_level), 32'd4);
        chk("ov_head",     32'(cmd_code),   32'd5);
        chk("ov_not_yet",  32'(overflow),   32'd0);
        step();
        chk("ov_lvl_hold", 32'(fifo_level), 32'd4);
        key_in = 8'h02; step();
        key_in = 8'h00;
        chk("ov_set", 32'(overflow), 32'd1);
        step();
        cmd_ready = 1'b1; step();
        chk("ov_pp_lvl",  32'(fifo_level), 32'd4);
        chk("ov_pp_code", 32'(cmd_code),   32'd6);
        step();
        chk("ov_pp2_lvl",  32'(fifo_level), 32'd4);
        chk("ov_pp2_code", 32'(cmd_code),   32'd7);
        step();
        chk("ov_d3_lvl",  32'(fifo_level), 32'd3);
        chk("ov_d3_code", 32'(cmd_code),   32'd0);
        step();
        chk("ov_d2_code", 32'(cmd_code),   32'd1);
        step();
        chk("ov_d1_code", 32'(cmd_code),   32'd2);
        chk("ov_d1_lvl",  32'(fifo_level), 32'd1);
        step();
        chk("ov_drained", 32'(fifo_level), 32'd0);
        chk("ov_sticky",  32'(overflow),   32'd1);

        // esc_retry with enter_next pending: flush leaves esc_retry alone
        cmd_ready = 1'b0;
        key_in = 8'h20; step();
        key_in = 8'h40; step();
        key_in = 8'h80; step();
        key_in = 8'h00; step();
        chk("fl_pre_lvl", 32'(fifo_level), 32'd3);
        key_in = 8'h30; step();
        key_in = 8'h00; step();
        chk("fl_lvl",   32'(fifo_level), 32'd1);
        chk("fl_code",  32'(cmd_code),   32'd4);
        chk("fl_valid", 32'(cmd_valid),  32'd1);
        step();
        chk("fl_lvl_hold", 32'(fifo_level), 32'd1);
        cmd_ready = 1'b1; step();
        chk("fl_pop", 32'(cmd_valid), 32'd0);

        // Reset while full with a_left held
        cmd_ready = 1'b0;
        key_in = 8'h20; step();
        key_in = 8'h40; step();
        key_in = 8'h80; step();
        key_in = 8'h01; step();
        step();
        chk("rs_full", 32'(fifo_level), 32'd4);
        reset = 1'b1; step(); step();
        chk_zero("rs_mid");
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("rs_held_k%0d", k), 32'(cmd_valid), 32'd0);
        end
        key_in = 8'h00; step();
        key_in = 8'h01; step();
        step();
        chk("rs_repress_valid", 32'(cmd_valid),  32'd1);
        chk("rs_repress_code",  32'(cmd_code),   32'd0);
        chk("rs_repress_rep",   32'(cmd_repeat), 32'd0);
        key_in = 8'h00; cmd_ready = 1'b1; step();
        chk("rs_final_empty", 32'(cmd_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
